// File: rtl/bcd_scan_driver.sv
// Binary-to-BCD converter (sequential double dabble) feeding a five-digit
// multiplexed scanner with double-buffered display registers.
module bcd_scan_driver #(
  parameter int unsigned scanDivisor = 50000
) (
  input  logic        iClk,
  input  logic        nRst,
  input  logic [15:0] iValue,
  input  logic        iValid,
  output logic        oReady,
  input  logic        iBlink,
  input  logic        iBlankLz,
  output logic [3:0]  oNum,
  output logic [4:0]  oDigitSel,
  output logic        oBlink
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    COMMIT  = 2'd2
  } state_t;

  localparam logic [31:0] DIV_LAST = 32'(scanDivisor - 1);

  // Conversion engine state
  state_t          state_q, state_d;
  logic [15:0]     bin_q, bin_d;
  logic [19:0]     bcd_q, bcd_d;
  logic [3:0]      iter_q, iter_d;
  logic            blink_lat_q, blink_lat_d;
  logic            blank_lz_q, blank_lz_d;
  logic            ready_q, ready_d;

  // Display buffer
  logic [4:0][3:0] dig_q, dig_d;
  logic [4:0]      blank_q, blank_d;
  logic            oblink_q, oblink_d;

  // Scanner
  logic [31:0]     div_q, div_d;
  logic [2:0]      idx_q, idx_d;
  logic [3:0]      num_q, num_d;
  logic [4:0]      sel_q, sel_d;

  logic [19:0]     bcd_adj;
  logic [4:0]      nib_zero;
  logic [4:0]      blank_calc;

  // Per-nibble add-3 correction applied before each shift.
  for (genvar gi = 0; gi < 5; gi++) begin : g_adj
    assign bcd_adj[gi*4 +: 4] = (bcd_q[gi*4 +: 4] >= 4'd5) ?
                                (bcd_q[gi*4 +: 4] + 4'd3) : bcd_q[gi*4 +: 4];
    assign nib_zero[gi] = (bcd_q[gi*4 +: 4] == 4'd0);
  end

  // A position is blank when it and every more significant digit are zero;
  // the units digit always shows.
  assign blank_calc[0] = 1'b0;
  for (genvar gi = 1; gi < 5; gi++) begin : g_blank
    assign blank_calc[gi] = blank_lz_q & (&nib_zero[4:gi]);
  end

  always_comb begin
    state_d     = state_q;
    bin_d       = bin_q;
    bcd_d       = bcd_q;
    iter_d      = iter_q;
    blink_lat_d = blink_lat_q;
    blank_lz_d  = blank_lz_q;
    dig_d       = dig_q;
    blank_d     = blank_q;
    oblink_d    = oblink_q;

    case (state_q)
      IDLE: begin
        if (iValid) begin
          bin_d       = iValue;
          bcd_d       = 20'd0;
          iter_d      = 4'd0;
          blink_lat_d = iBlink;
          blank_lz_d  = iBlankLz;
          state_d     = CONVERT;
        end
      end
      CONVERT: begin
        {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
        iter_d         = iter_q + 4'd1;
        if (iter_q == 4'd15) begin
          state_d = COMMIT;
        end
      end
      COMMIT: begin
        dig_d    = bcd_q;
        blank_d  = blank_calc;
        oblink_d = blink_lat_q;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    ready_d = (state_d == IDLE);
  end

  always_comb begin
    div_d = div_q + 32'd1;
    idx_d = idx_q;
    if (div_q == DIV_LAST) begin
      div_d = 32'd0;
      idx_d = (idx_q == 3'd4) ? 3'd0 : (idx_q + 3'd1);
    end

    num_d = 4'd0;
    sel_d = 5'b11111;
    if (idx_q <= 3'd4) begin
      num_d = dig_q[idx_q];
      if (!blank_q[idx_q]) begin
        sel_d = ~(5'b00001 << idx_q);
      end
    end
  end

  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      state_q     <= IDLE;
      bin_q       <= '0;
      bcd_q       <= '0;
      iter_q      <= '0;
      blink_lat_q <= 1'b0;
      blank_lz_q  <= 1'b0;
      ready_q     <= 1'b1;
      dig_q       <= '0;
      blank_q     <= '0;
      oblink_q    <= 1'b0;
      div_q       <= '0;
      idx_q       <= '0;
      num_q       <= '0;
      sel_q       <= 5'b11111;
    end else begin
      state_q     <= state_d;
      bin_q       <= bin_d;
      bcd_q       <= bcd_d;
      iter_q      <= iter_d;
      blink_lat_q <= blink_lat_d;
      blank_lz_q  <= blank_lz_d;
      ready_q     <= ready_d;
      dig_q       <= dig_d;
      blank_q     <= blank_d;
      oblink_q    <= oblink_d;
      div_q       <= div_d;
      idx_q       <= idx_d;
      num_q       <= num_d;
      sel_q       <= sel_d;
    end
  end

  assign oReady    = ready_q;
  assign oNum      = num_q;
  assign oDigitSel = sel_q;
  assign oBlink    = oblink_q;

endmodule

// File: tb/tb_bcd_scan_driver.sv
// Self-checking bench for bcd_scan_driver: decimal/scan behaviour is
// predicted arithmetically from the cycle count since reset release.
module tb_bcd_scan_driver;
  localparam int D = 2;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic [15:0] iValue = '0;
  logic        iValid = 1'b0;
  logic        iBlink = 1'b0;
  logic        iBlankLz = 1'b0;
  logic        oReady;
  logic [3:0]  oNum;
  logic [4:0]  oDigitSel;
  logic        oBlink;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int cur_val = 0;
  bit cur_blz = 1'b0;

  bcd_scan_driver #(.scanDivisor(D)) dut (
    .iClk(clk), .nRst(nrst), .iValue(iValue), .iValid(iValid),
    .oReady(oReady), .iBlink(iBlink), .iBlankLz(iBlankLz),
    .oNum(oNum), .oDigitSel(oDigitSel), .oBlink(oBlink)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge nrst) begin
    if (!nrst) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  function automatic int pow10(int k);
    int r = 1;
    for (int i = 0; i < k; i++) r = r * 10;
    return r;
  endfunction

  // Outputs after edge c reflect the slot selected after c-1 edges.
  function automatic logic [4:0] model_sel(int c, int v, bit blz);
    int slot;
    if (c == 0) return 5'b11111;
    slot = ((c - 1) / D) % 5;
    if (blz && slot > 0 && v < pow10(slot)) return 5'b11111;
    return ~(5'b00001 << slot);
  endfunction

  function automatic logic [3:0] model_num(int c, int v);
    int slot;
    if (c == 0) return 4'd0;
    slot = ((c - 1) / D) % 5;
    return 4'((v / pow10(slot)) % 10);
  endfunction

  task automatic start_req(input int v, input bit b, input bit z);
    @(negedge clk);
    iValue = 16'(v); iBlink = b; iBlankLz = z; iValid = 1'b1;
    @(negedge clk);
    iValid = 1'b0;
  endtask

  task automatic test_reset;
    repeat (7) @(negedge clk);
    #3 nrst = 1'b0;
    #1;
    checks++;
    if (oReady !== 1'b1 || oNum !== 4'd0 || oDigitSel !== 5'b11111 || oBlink !== 1'b0) begin
      failures++;
      $display("FAIL reset_async got ready=%b num=%0d sel=%b blink=%b exp 1 0 11111 0", oReady, oNum, oDigitSel, oBlink);
    end
    @(negedge clk); nrst = 1'b1;
    #1;
    checks++;
    if (oReady !== 1'b1 || oNum !== 4'd0 || oDigitSel !== 5'b11111) begin
      failures++;
      $display("FAIL reset_release got ready=%b num=%0d sel=%b exp 1 0 11111", oReady, oNum, oDigitSel);
    end
    @(negedge clk);
    checks++;
    if (oDigitSel !== 5'b11110 || oNum !== 4'd0) begin
      failures++;
      $display("FAIL reset_first_slot got sel=%b num=%0d exp 11110 0", oDigitSel, oNum);
    end
    $display("reset: released, first slot sel=%b", oDigitSel);
  endtask

  task automatic test_max;
    start_req(12345, 1'b0, 1'b0);
    for (int k = 0; k < 17; k++) begin
      if (k > 0) @(negedge clk);
      checks++;
      if (oReady !== 1'b0) begin
        failures++; $display("FAIL max_busy k=%0d got ready=%b exp 0", k, oReady);
      end
    end
    @(negedge clk);
    checks++;
    if (oReady !== 1'b1) begin failures++; $display("FAIL max_ready_back got %b exp 1", oReady); end
    cur_val = 12345; cur_blz = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (oDigitSel !== model_sel(cyc, cur_val, cur_blz) || oNum !== model_num(cyc, cur_val)) begin
        failures++;
        $display("FAIL max_disp got sel=%b num=%0d exp sel=%b num=%0d", oDigitSel, oNum,
                 model_sel(cyc, cur_val, cur_blz), model_num(cyc, cur_val));
      end
    end
    $display("max: value=12345 displayed");
  endtask

  task automatic test_full_scale;
    int vals[2] = '{65535, 0};
    bit blzs[2] = '{1'b0, 1'b1};
    for (int t = 0; t < 2; t++) begin
      start_req(vals[t], 1'b0, blzs[t]);
      repeat (17) @(negedge clk);
      checks++;
      if (oReady !== 1'b1) begin failures++; $display("FAIL full_ready v=%0d got %b exp 1", vals[t], oReady); end
      cur_val = vals[t]; cur_blz = blzs[t];
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        checks++;
        if (oDigitSel !== model_sel(cyc, cur_val, cur_blz) || oNum !== model_num(cyc, cur_val)) begin
          failures++;
          $display("FAIL full_disp v=%0d got sel=%b num=%0d exp sel=%b num=%0d", cur_val, oDigitSel, oNum,
                   model_sel(cyc, cur_val, cur_blz), model_num(cyc, cur_val));
        end
      end
      $display("full: value=%0d blank=%0d displayed", vals[t], blzs[t]);
    end
  endtask

  task automatic test_blank_blink;
    int vals[2] = '{407, 9};
    bit blks[2] = '{1'b1, 1'b0};
    for (int t = 0; t < 2; t++) begin
      start_req(vals[t], blks[t], 1'b1);
      repeat (17) @(negedge clk);
      checks++;
      if (oBlink !== blks[t]) begin
        failures++; $display("FAIL blink_commit v=%0d got %b exp %b", vals[t], oBlink, blks[t]);
      end
      cur_val = vals[t]; cur_blz = 1'b1;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        checks++;
        if (oDigitSel !== model_sel(cyc, cur_val, cur_blz) || oNum !== model_num(cyc, cur_val) ||
            oBlink !== blks[t]) begin
          failures++;
          $display("FAIL blank_disp v=%0d got sel=%b num=%0d blink=%b exp sel=%b num=%0d blink=%b",
                   cur_val, oDigitSel, oNum, oBlink, model_sel(cyc, cur_val, cur_blz),
                   model_num(cyc, cur_val), blks[t]);
        end
      end
      $display("blank_blink: value=%0d blink=%0d displayed", vals[t], blks[t]);
    end
  endtask

  task automatic test_busy;
    logic exp_ready;
    int exp_val;
    @(negedge clk);
    iValue = 16'd100; iBlink = 1'b0; iBlankLz = 1'b0; iValid = 1'b1;
    for (int k = 0; k <= 45; k++) begin
      @(negedge clk);
      if (k == 5)  iValue = 16'd200;
      if (k == 18) iValid = 1'b0;
      exp_ready = (k == 17 || k >= 35);
      checks++;
      if (oReady !== exp_ready) begin
        failures++; $display("FAIL busy_ready k=%0d got %b exp %b", k, oReady, exp_ready);
      end
      if (k >= 18) begin
        exp_val = (k <= 35) ? 100 : 200;
        checks++;
        if (oDigitSel !== model_sel(cyc, exp_val, 1'b0) || oNum !== model_num(cyc, exp_val)) begin
          failures++;
          $display("FAIL busy_disp k=%0d got sel=%b num=%0d exp sel=%b num=%0d", k, oDigitSel, oNum,
                   model_sel(cyc, exp_val, 1'b0), model_num(cyc, exp_val));
        end
      end
    end
    cur_val = 200; cur_blz = 1'b0;
    $display("busy: 100 then 200 committed in order");
  endtask

  task automatic test_reset_mid;
    start_req(58, 1'b1, 1'b1);
    repeat (18) @(negedge clk);
    start_req(777, 1'b0, 1'b0);
    repeat (8) @(negedge clk);
    #2 nrst = 1'b0;
    #1;
    checks++;
    if (oReady !== 1'b1 || oNum !== 4'd0 || oDigitSel !== 5'b11111 || oBlink !== 1'b0) begin
      failures++;
      $display("FAIL midreset_async got ready=%b num=%0d sel=%b blink=%b exp 1 0 11111 0", oReady, oNum, oDigitSel, oBlink);
    end
    @(negedge clk); nrst = 1'b1;
    cur_val = 0; cur_blz = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      checks++;
      if (oReady !== 1'b1 || oBlink !== 1'b0 || oDigitSel !== model_sel(cyc, 0, 1'b0) ||
          oNum !== model_num(cyc, 0)) begin
        failures++;
        $display("FAIL midreset_disp i=%0d got ready=%b blink=%b sel=%b num=%0d exp 1 0 %b %0d", i, oReady,
                 oBlink, oDigitSel, oNum, model_sel(cyc, 0, 1'b0), model_num(cyc, 0));
      end
    end
    $display("reset_mid: aborted 777, display cleared");
  endtask

  task automatic test_random;
    int v;
    bit b, z;
    for (int t = 0; t < 15; t++) begin
      v = int'($urandom_range(0, 65535));
      b = 1'($urandom_range(0, 1));
      z = 1'($urandom_range(0, 1));
      if (t < 5) v = v % pow10(t + 1);
      start_req(v, b, z);
      for (int k = 0; k < 17; k++) begin
        if (k > 0) @(negedge clk);
        checks++;
        if (oReady !== 1'b0) begin failures++; $display("FAIL rand_busy v=%0d k=%0d got %b exp 0", v, k, oReady); end
      end
      @(negedge clk);
      checks++;
      if (oReady !== 1'b1 || oBlink !== b) begin
        failures++; $display("FAIL rand_commit v=%0d got ready=%b blink=%b exp 1 %b", v, oReady, oBlink, b);
      end
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        checks++;
        if (oDigitSel !== model_sel(cyc, v, z) || oNum !== model_num(cyc, v)) begin
          failures++;
          $display("FAIL rand_disp v=%0d z=%0d got sel=%b num=%0d exp sel=%b num=%0d", v, z, oDigitSel, oNum,
                   model_sel(cyc, v, z), model_num(cyc, v));
        end
      end
      $display("random: value=%0d blink=%0d blank=%0d", v, b, z);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    test_reset();
    test_max();
    test_full_scale();
    test_blank_blink();
    test_busy();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
